ai_shot_master: RTL and testbench
=================================

// Module: ai_shot_master
// PURPOSE
//  Upstream driver for the ai shot-selection slave. Keeps the shot-history board
//  (100 cells, 2 bits each) and the remaining-ships mask, updated from game results.
//  On shot_req it acts as Avalon-MM master: writes board words (addr 1..8), mask (addr 9),
//  then start (addr 0), reads addr 0 for the chosen cell, and returns it to the game FSM.
// PARAMETERS
//  NUM_CELLS   100  board cells; legal index 0..NUM_CELLS-1
//  NUM_SHIPS   5    ships; width of mask, reset value all ones
//  NUM_WORDS   8    32-bit board words sent, addr 1..NUM_WORDS; mask goes to NUM_WORDS+1
// PORTS
//  clock           in   1   single clock, rising edge
//  reset           in   1   synchronous, active-high
//  result_valid    in   1   one-cycle pulse: apply a shot result
//  result_cell     in   7   cell index of result
//  result_code     in   2   01 miss, 10 hit, 11 sunk (00 ignored)
//  result_ship     in   3   ship id 0..4, used only when code==11
//  shot_req        in   1   one-cycle pulse: request next AI shot
//  busy            out  1   high from accepted shot_req until shot_valid cycle inclusive
//  shot_valid      out  1   one-cycle pulse, shot_cell/shot_err valid
//  shot_cell       out  7   chosen cell = av_readdata[6:0]
//  shot_err        out  1   readdata[6:0] >= NUM_CELLS (qualifies shot_valid)
//  pend_ovf        out  1   sticky: result lost while busy; cleared only by reset
//  av_address      out  4   Avalon word address to ai
//  av_write        out  1   Avalon write strobe
//  av_read         out  1   Avalon read strobe
//  av_writedata    out  32  Avalon write data
//  av_waitrequest  in   1   slave stall
//  av_readdata     in   32  slave read data
// BEHAVIOUR
//  Reset: board=0, mask=all ones, pending empty, FSM IDLE; all outputs 0; pend_ovf=0.
//   Reset mid-transfer aborts: av_write/av_read/busy low after that edge; no shot_valid.
//  Board: cell i at bits [2i+1:2i] of a 256-bit vector; word k (addr k) = bits [32k-1:32k-32].
//   Unused bits 200..255 are 0. Result write overwrites the cell code.
//   Code 11 with result_ship<NUM_SHIPS clears mask[result_ship]; ship>=NUM_SHIPS: cell updates, mask unchanged.
//   result_cell>=NUM_CELLS or code 00: whole result ignored.
//  Results while busy: stored in 1-entry pending reg, applied on the edge FSM enters IDLE.
//   Second result while pending full -> dropped, pend_ovf<=1. Board/mask frozen while busy,
//   so the snapshot sent is consistent.
//  FSM: IDLE -shot_req-> WR (idx=1) -> ... WR idx=NUM_WORDS+1 -> START -> RD -> DONE -> IDLE.
//   WR: av_write=1, av_address=idx, av_writedata=word idx (or {27'b0,mask} at idx 9).
//   START: av_write=1, addr 0, data 0. RD: av_read=1, addr 0.
//   A transfer completes on an edge where av_waitrequest=0; until then address, data and
//   strobe held stable; FSM advances only on completion. RD captures av_readdata on completion.
//   DONE: shot_valid=1 for exactly one cycle, busy=1; then IDLE. av_write and av_read never both 1.
//  Latency, waitrequest always 0: req edge at cycle 0; writes cycles 1..10 (addr 1..9,0);
//   read cycle 11; shot_valid cycle 12. Each stall cycle adds one cycle.
//  shot_req while busy ignored; shot_req and result_valid same cycle in IDLE: result applied
//   to board first, the new value is sent.
//  shot_cell/shot_err hold last value after DONE until the next DONE.
// TESTING
//  1 Reset 3 cycles -> all outputs 0; first shot sends addr 9 data 0x0000001F.
//  2 Fresh board, shot_req, waitrequest=0, readdata=0x2A -> addr seq 1..9,0 data 0..0,0x1F,0;
//    read cycle 11; shot_valid cycle 12, shot_cell=42, shot_err=0.
//  3 result hit cell 42 then shot_req -> addr 3 data 0x00200000, others 0; sunk ship 2 -> addr 9 data 0x1B.
//  4 waitrequest high 5 cycles on addr 4 write and 20 cycles on read -> signals held stable,
//    no advance; shot_valid at cycle 37; readdata=0x64 -> shot_err=1.
//  5 Two results during busy -> first applied on IDLE entry, second dropped, pend_ovf=1.
//  6 Reset asserted during RD stall -> av_read=0, busy=0 after edge; no shot_valid; board cleared.

Source files
------------

// File: rtl/ai_shot_if.sv
// ---------------------------------------------------------------------------
// ai_shot_if
// Avalon-MM link between the shot master and the ai shot-selection slave.
//
// Handshake: the master raises av_write or av_read together with av_address
// (and av_writedata for writes). The transfer completes on the first rising
// clock edge where av_waitrequest is 0. Until that edge the master holds
// address, data and strobe stable. av_readdata is sampled on the completing
// edge of a read. av_write and av_read are never high together.
//
// Signals
//   av_address      master -> slave  4   word address
//   av_write        master -> slave  1   write strobe
//   av_read         master -> slave  1   read strobe
//   av_writedata    master -> slave  32  write data
//   av_waitrequest  slave -> master  1   stall, transfer completes when low
//   av_readdata     slave -> master  32  read data
// ---------------------------------------------------------------------------
interface ai_shot_if;
   logic [3:0]  av_address;
   logic        av_write;
   logic        av_read;
   logic [31:0] av_writedata;
   logic        av_waitrequest;
   logic [31:0] av_readdata;

   modport master (
      output av_address, av_write, av_read, av_writedata,
      input  av_waitrequest, av_readdata
   );

   modport slave (
      input  av_address, av_write, av_read, av_writedata,
      output av_waitrequest, av_readdata
   );
endinterface

// File: rtl/ai_shot_master.sv
// ---------------------------------------------------------------------------
// ai_shot_master
// Keeps the shot-history board (2 bits per cell) and the remaining-ships mask,
// and on shot_req pushes a snapshot of both to the ai slave over Avalon-MM:
// board words at addr 1..NUM_WORDS, mask at NUM_WORDS+1, start at addr 0,
// then reads addr 0 for the chosen cell and reports it as shot_cell.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   result_*            one-cycle result pulse: cell, code (01/10/11), ship id
//   shot_req            one-cycle request for the next AI shot
//   busy                high from the accepted request through the shot_valid cycle
//   shot_valid          one-cycle pulse, shot_cell/shot_err valid
//   shot_cell/shot_err  chosen cell and out-of-range flag, held until next shot
//   pend_ovf            sticky flag: a result was lost while busy
//   dbg_state           current FSM state encoding
//   bus                 Avalon-MM master side (see ai_shot_if)
// ---------------------------------------------------------------------------
module ai_shot_master #(
   parameter int NUM_CELLS = 100,
   parameter int NUM_SHIPS = 5,
   parameter int NUM_WORDS = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       result_valid,
   input  logic [6:0] result_cell,
   input  logic [1:0] result_code,
   input  logic [2:0] result_ship,
   input  logic       shot_req,
   output logic       busy,
   output logic       shot_valid,
   output logic [6:0] shot_cell,
   output logic       shot_err,
   output logic       pend_ovf,
   output logic [2:0] dbg_state,
   ai_shot_if.master  bus
);

   localparam int         BW       = 32 * NUM_WORDS;
   localparam int         BB       = 2 * NUM_CELLS;
   localparam logic [3:0] MASK_IDX = 4'(NUM_WORDS + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR    = 3'd1,
      START = 3'd2,
      RD    = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t               state;
   logic [3:0]           idx;
   logic [BB-1:0]        board, board_nx;
   logic [NUM_SHIPS-1:0] mask, mask_nx;

   logic                 pend_valid;
   logic [6:0]           pend_cell;
   logic [1:0]           pend_code;
   logic [2:0]           pend_ship;

   logic                 in_legal;
   logic                 app_valid;
   logic [6:0]           app_cell;
   logic [1:0]           app_code;
   logic [2:0]           app_ship;

   // Only the low 7 bits of read data carry the chosen cell.
   logic                 unused_rd;
   assign unused_rd = ^bus.av_readdata[31:7];

   assign dbg_state = state;

   // Word k of the board (unused high bits zero), or the mask word at MASK_IDX.
   function automatic logic [31:0] word_of(input logic [BB-1:0]        b,
                                           input logic [NUM_SHIPS-1:0] m,
                                           input logic [3:0]           k);
      logic [BW-1:0] ext;
      ext          = '0;
      ext[BB-1:0]  = b;
      if (k == MASK_IDX) word_of = 32'(m);
      else               word_of = ext[32*(int'(k)-1) +: 32];
   endfunction

   assign in_legal = result_valid && (result_code != 2'b00) &&
                     (int'(result_cell) < NUM_CELLS);

   // Which result (if any) lands on the board this edge. The board only moves
   // in IDLE or on the DONE->IDLE edge, so the snapshot sent stays consistent.
   // On that DONE edge a held pending result takes priority over a fresh one.
   always_comb begin
      app_valid = 1'b0;
      app_cell  = result_cell;
      app_code  = result_code;
      app_ship  = result_ship;
      if (state == IDLE) begin
         app_valid = in_legal;
      end else if (state == DONE) begin
         if (pend_valid) begin
            app_valid = 1'b1;
            app_cell  = pend_cell;
            app_code  = pend_code;
            app_ship  = pend_ship;
         end else begin
            app_valid = in_legal;
         end
      end
   end

   always_comb begin
      board_nx = board;
      mask_nx  = mask;
      if (app_valid) begin
         board_nx[{app_cell, 1'b0} +: 2] = app_code;
         if (app_code == 2'b11 && int'(app_ship) < NUM_SHIPS)
            mask_nx[app_ship] = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         idx              <= 4'd0;
         board            <= '0;
         mask             <= '1;
         pend_valid       <= 1'b0;
         pend_cell        <= 7'd0;
         pend_code        <= 2'd0;
         pend_ship        <= 3'd0;
         pend_ovf         <= 1'b0;
         busy             <= 1'b0;
         shot_valid       <= 1'b0;
         shot_cell        <= 7'd0;
         shot_err         <= 1'b0;
         bus.av_address   <= 4'd0;
         bus.av_write     <= 1'b0;
         bus.av_read      <= 1'b0;
         bus.av_writedata <= 32'd0;
      end else begin
         board      <= board_nx;
         mask       <= mask_nx;
         shot_valid <= 1'b0;

         // Results arriving mid-transfer are parked; a second one is lost.
         if (state == WR || state == START || state == RD) begin
            if (in_legal) begin
               if (!pend_valid) begin
                  pend_valid <= 1'b1;
                  pend_cell  <= result_cell;
                  pend_code  <= result_code;
                  pend_ship  <= result_ship;
               end else begin
                  pend_ovf <= 1'b1;
               end
            end
         end else if (state == DONE) begin
            pend_valid <= 1'b0;
            if (in_legal && pend_valid) pend_ovf <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (shot_req) begin
                  state            <= WR;
                  idx              <= 4'd1;
                  busy             <= 1'b1;
                  bus.av_write     <= 1'b1;
                  bus.av_address   <= 4'd1;
                  // Use the post-update board so a same-cycle result is sent.
                  bus.av_writedata <= word_of(board_nx, mask_nx, 4'd1);
               end
            end
            WR: begin
               if (!bus.av_waitrequest) begin
                  if (idx == MASK_IDX) begin
                     state            <= START;
                     bus.av_address   <= 4'd0;
                     bus.av_writedata <= 32'd0;
                  end else begin
                     idx              <= idx + 4'd1;
                     bus.av_address   <= idx + 4'd1;
                     bus.av_writedata <= word_of(board, mask, idx + 4'd1);
                  end
               end
            end
            START: begin
               if (!bus.av_waitrequest) begin
                  state          <= RD;
                  bus.av_write   <= 1'b0;
                  bus.av_read    <= 1'b1;
                  bus.av_address <= 4'd0;
               end
            end
            RD: begin
               if (!bus.av_waitrequest) begin
                  state       <= DONE;
                  bus.av_read <= 1'b0;
                  shot_cell   <= bus.av_readdata[6:0];
                  shot_err    <= (int'(bus.av_readdata[6:0]) >= NUM_CELLS);
                  shot_valid  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ai_shot_master.sv
// ---------------------------------------------------------------------------
// tb_ai_shot_master
// Directed bench for ai_shot_master. Drivers push the expected Avalon
// transfers and shot responses into queues; a slave model and a shot monitor
// pop and compare them as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_ai_shot_master;

   logic       clock;
   logic       reset;
   logic       result_valid;
   logic [6:0] result_cell;
   logic [1:0] result_code;
   logic [2:0] result_ship;
   logic       shot_req;
   logic       busy;
   logic       shot_valid;
   logic [6:0] shot_cell;
   logic       shot_err;
   logic       pend_ovf;
   logic [2:0] dbg_state;

   ai_shot_if bus ();

   ai_shot_master dut (
      .clock        (clock),
      .reset        (reset),
      .result_valid (result_valid),
      .result_cell  (result_cell),
      .result_code  (result_code),
      .result_ship  (result_ship),
      .shot_req     (shot_req),
      .busy         (busy),
      .shot_valid   (shot_valid),
      .shot_cell    (shot_cell),
      .shot_err     (shot_err),
      .pend_ovf     (pend_ovf),
      .dbg_state    (dbg_state),
      .bus          (bus)
   );

   // ---------------- clock / reset ----------------
   int cyc = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   // bus entry: {cycle[15:0], is_read, addr[3:0], data[31:0]}
   logic [52:0] bus_q[$];
   // shot entry: {cycle[15:0], err, cell[6:0]}
   logic [23:0] shot_q[$];

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
   endtask

   // ---------------- slave model / bus monitor ----------------
   int          wr4_stall = 0;
   int          rd_stall  = 0;
   logic [31:0] rd_data   = 32'd0;
   int          stall_left = 0;
   bit          active = 1'b0;
   logic [40:0] held;
   logic [40:0] cur;
   logic [52:0] bus_e;

   always @(negedge clock) begin
      cur = {bus.av_address, bus.av_write, bus.av_read, 2'b00, bus.av_writedata};
      bus.av_readdata = rd_data;
      if (bus.av_write || bus.av_read) begin
         check("strobe_excl", {63'd0, bus.av_write & bus.av_read}, 64'd0);
         if (!active) begin
            active = 1'b1;
            held   = cur;
            if (bus.av_read)                  stall_left = rd_stall;
            else if (bus.av_address == 4'd4)  stall_left = wr4_stall;
            else                              stall_left = 0;
         end else if (bus.av_waitrequest) begin
            check("hold_stable", {23'd0, cur}, {23'd0, held});
         end
         if (stall_left > 0) begin
            bus.av_waitrequest = 1'b1;
            stall_left--;
         end else begin
            bus.av_waitrequest = 1'b0;
            active = 1'b0;
            if (bus_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_xfer: addr %0d wr %0b rd %0b at cycle %0d",
                        bus.av_address, bus.av_write, bus.av_read, cyc);
            end else begin
               bus_e = bus_q.pop_front();
               check("xfer", {11'd0, 16'(cyc), bus.av_read, bus.av_address,
                              bus.av_read ? 32'd0 : bus.av_writedata},
                     {11'd0, bus_e});
            end
         end
      end else begin
         bus.av_waitrequest = 1'b0;
         active = 1'b0;
      end
   end

   // ---------------- shot monitor ----------------
   logic [23:0] shot_e;

   always @(negedge clock) begin
      if (shot_valid) begin
         if (shot_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_shot: cell %0d err %0b at cycle %0d", shot_cell, shot_err, cyc);
         end else begin
            shot_e = shot_q.pop_front();
            check("shot", {40'd0, 16'(cyc), shot_err, shot_cell}, {40'd0, shot_e});
         end
      end
   end

   // ---------------- drivers ----------------
   logic [31:0] exp_w [1:9];

   task automatic set_w(input logic [31:0] a1, input logic [31:0] a3,
                        input logic [31:0] a7, input logic [31:0] a9);
      for (int i = 1; i <= 9; i++) exp_w[i] = 32'd0;
      exp_w[1] = a1;
      exp_w[3] = a3;
      exp_w[7] = a7;
      exp_w[9] = a9;
   endtask

   // Called at a negedge; drives a one-cycle result pulse.
   task automatic drive_result(input logic [6:0] c, input logic [1:0] code, input logic [2:0] s);
      result_valid = 1'b1;
      result_cell  = c;
      result_code  = code;
      result_ship  = s;
      @(negedge clock);
      result_valid = 1'b0;
   endtask

   // Called at a negedge (cycle 0). Pushes the expected transfers and, when
   // done=1, the expected shot, then waits for busy to fall.
   task automatic shot(input logic [31:0] rdata, input int s4, input int srd,
                       input logic [6:0] ecell, input logic eerr, input bit done,
                       input logic rv, input logic [6:0] rc, input logic [1:0] rcode,
                       input logic [2:0] rs);
      int x;
      int acc;
      x         = cyc;
      acc       = 0;
      wr4_stall = s4;
      rd_stall  = srd;
      rd_data   = rdata;
      for (int j = 1; j <= 9; j++) begin
         if (j == 4) acc += s4;
         bus_q.push_back({16'(x + j + acc), 1'b0, 4'(j), exp_w[j]});
      end
      bus_q.push_back({16'(x + 10 + acc), 1'b0, 4'd0, 32'd0});
      acc += srd;
      if (done) begin
         bus_q.push_back({16'(x + 11 + acc), 1'b1, 4'd0, 32'd0});
         shot_q.push_back({16'(x + 12 + acc), eerr, ecell});
      end
      shot_req     = 1'b1;
      result_valid = rv;
      result_cell  = rc;
      result_code  = rcode;
      result_ship  = rs;
      @(negedge clock);
      shot_req     = 1'b0;
      result_valid = 1'b0;
      if (done) begin
         check("busy_rise", {63'd0, busy}, 64'd1);
         for (int n = 0; n < 200; n++) begin
            if (!busy) break;
            @(negedge clock);
         end
         check("busy_fall_cycle", 64'(cyc), 64'(x + 13 + acc));
         check("shot_hold", {56'd0, shot_err, shot_cell}, {56'd0, eerr, ecell});
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      reset        = 1'b1;
      result_valid = 1'b0;
      result_cell  = 7'd0;
      result_code  = 2'd0;
      result_ship  = 3'd0;
      shot_req     = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Reset state.
      check("rst_busy",      {63'd0, busy},             64'd0);
      check("rst_shot_valid",{63'd0, shot_valid},       64'd0);
      check("rst_shot_cell", {57'd0, shot_cell},        64'd0);
      check("rst_shot_err",  {63'd0, shot_err},         64'd0);
      check("rst_pend_ovf",  {63'd0, pend_ovf},         64'd0);
      check("rst_strobes",   {62'd0, bus.av_write, bus.av_read}, 64'd0);
      check("rst_addr_data", {28'd0, bus.av_address, bus.av_writedata}, 64'd0);

      // Fresh board, mask all ones, slave picks 42.
      set_w(32'd0, 32'd0, 32'd0, 32'h1F);
      shot(32'h2A, 0, 0, 7'd42, 1'b0, 1'b1, 1'b0, 7'd0, 2'd0, 3'd0);

      // Hit on cell 42 lands in word 3 bits 21:20.
      drive_result(7'd42, 2'b10, 3'd0);
      set_w(32'd0, 32'h0020_0000, 32'd0, 32'h1F);
      shot(32'h05, 0, 0, 7'd5, 1'b0, 1'b1, 1'b0, 7'd0, 2'd0, 3'd0);

      // Sunk ship 2 at cell 0; ignored out-of-range and code-00 results;
      // sunk with ship id 7 updates the cell only; miss on cell 99 arrives
      // in the same cycle as shot_req and must be sent.
      drive_result(7'd0,   2'b11, 3'd2);
      drive_result(7'd100, 2'b10, 3'd0);
      drive_result(7'd1,   2'b00, 3'd0);
      drive_result(7'd2,   2'b11, 3'd7);
      set_w(32'h33, 32'h0020_0000, 32'h40, 32'h1B);
      shot(32'h63, 0, 0, 7'd99, 1'b0, 1'b1, 1'b1, 7'd99, 2'b01, 3'd0);

      // Stalls: 5 cycles on the addr 4 write, 20 on the read; cell 100 is out of range.
      shot(32'h64, 5, 20, 7'd100, 1'b1, 1'b1, 1'b0, 7'd0, 2'd0, 3'd0);
      check("ovf_before", {63'd0, pend_ovf}, 64'd0);

      // Two results while busy: first parked and applied at IDLE entry, second lost.
      fork
         shot(32'h07, 0, 0, 7'd7, 1'b0, 1'b1, 1'b0, 7'd0, 2'd0, 3'd0);
         begin
            @(negedge clock);
            @(negedge clock);
            drive_result(7'd42, 2'b11, 3'd0);
            drive_result(7'd5,  2'b10, 3'd0);
         end
      join
      check("ovf_after", {63'd0, pend_ovf}, 64'd1);
      set_w(32'h33, 32'h0030_0000, 32'h40, 32'h1A);
      shot(32'h10, 0, 0, 7'd16, 1'b0, 1'b1, 1'b0, 7'd0, 2'd0, 3'd0);

      // Reset during a stalled read: transfer aborts, no shot, board cleared.
      shot(32'h11, 0, 20, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 3'd0);
      repeat (13) @(negedge clock);
      check("pre_rst_read", {63'd0, bus.av_read}, 64'd1);
      reset = 1'b1;
      @(negedge clock);
      check("abort_read",  {63'd0, bus.av_read},  64'd0);
      check("abort_write", {63'd0, bus.av_write}, 64'd0);
      check("abort_busy",  {63'd0, busy},         64'd0);
      check("abort_ovf",   {63'd0, pend_ovf},     64'd0);
      check("abort_cell",  {57'd0, shot_cell},    64'd0);
      reset = 1'b0;
      @(negedge clock);
      set_w(32'd0, 32'd0, 32'd0, 32'h1F);
      shot(32'h00, 0, 0, 7'd0, 1'b0, 1'b1, 1'b0, 7'd0, 2'd0, 3'd0);

      repeat (5) @(negedge clock);
      check("bus_q_empty",  64'(bus_q.size()),  64'd0);
      check("shot_q_empty", 64'(shot_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
